// File: rtl/ec_point_unit_if.sv
// ec_point_unit_if: request/response bundle for the elliptic-curve point unit.
//   in_valid/in_ready : request handshake (accept on in_valid & in_ready)
//   mode              : 0 = add P+Q, 1 = double 2P
//   px/py/p_inf       : operand P (affine, or point at infinity)
//   qx/qy/q_inf       : operand Q (ignored when doubling)
//   rx/ry/r_inf       : result, valid with the out_valid pulse and held afterwards
//   out_valid         : one-cycle completion pulse
// master = requester (scalar-multiply controller), slave = ec_point_unit.
interface ec_point_unit_if #(
  parameter int unsigned WIDTH = 256
);
  logic             in_valid;
  logic             in_ready;
  logic             mode;
  logic [WIDTH-1:0] px;
  logic [WIDTH-1:0] py;
  logic             p_inf;
  logic [WIDTH-1:0] qx;
  logic [WIDTH-1:0] qy;
  logic             q_inf;
  logic [WIDTH-1:0] rx;
  logic [WIDTH-1:0] ry;
  logic             r_inf;
  logic             out_valid;

  modport master (
    output in_valid, mode, px, py, p_inf, qx, qy, q_inf,
    input  in_ready, rx, ry, r_inf, out_valid
  );

  modport slave (
    input  in_valid, mode, px, py, p_inf, qx, qy, q_inf,
    output in_ready, rx, ry, r_inf, out_valid
  );
endinterface

// File: rtl/ec_point_unit.sv
// ec_point_unit: affine point add / double on y^2 = x^3 + A*x + B over GF(PRIME).
// Iterative: one bit-serial MSB-first modular multiplier and one binary
// extended-Euclid inverter, sequenced by an FSM.
//   clk    : clock
//   rst    : synchronous active-high reset (aborts any operation in flight)
//   io_bus : request/response bundle (slave side), see ec_point_unit_if
module ec_point_unit #(
  parameter int unsigned      WIDTH = 256,
  parameter logic [WIDTH-1:0] PRIME = WIDTH'(256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F),
  parameter logic [WIDTH-1:0] A     = '0
) (
  input  logic           clk,
  input  logic           rst,
  ec_point_unit_if.slave io_bus
);
  localparam int unsigned CW = $clog2(2 * WIDTH + 1);

  typedef enum logic [3:0] {
    StIdle, StCheck, StNum, StInv, StLam, StSq, StSub1, StSub2, StYm, StDone
  } state_e;

  function automatic logic [WIDTH-1:0] f_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, PRIME}) s = s - {1'b0, PRIME};
    return s[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] f_sub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[WIDTH]) d = d + {1'b0, PRIME};
    return d[WIDTH-1:0];
  endfunction

  // x/2 mod PRIME: PRIME is odd, so an odd x becomes even after adding PRIME.
  function automatic logic [WIDTH-1:0] f_half(input logic [WIDTH-1:0] x);
    logic [WIDTH:0] s;
    s = x[0] ? ({1'b0, x} + {1'b0, PRIME}) : {1'b0, x};
    return s[WIDTH:1];
  endfunction

  state_e r_state, w_state_next;

  logic             r_mode, r_pinf, r_qinf, r_dbl, r_rinf;
  logic [WIDTH-1:0] r_px, r_py, r_qx, r_qy;
  logic [WIDTH-1:0] r_num, r_u, r_v, r_x1, r_x2, r_lam, r_t;
  logic [WIDTH-1:0] r_mul_a, r_mul_b, r_mul_acc;
  logic [WIDTH-1:0] r_rx, r_ry;
  logic [CW-1:0]    r_cnt;

  // Request classification
  logic             w_x_eq, w_y_eq, w_dbl;
  logic             w_triv, w_t_inf;
  logic [WIDTH-1:0] w_t_x, w_t_y;

  assign w_x_eq = (r_px == r_qx);
  assign w_y_eq = (r_py == r_qy);
  assign w_dbl  = r_mode | (~r_pinf & ~r_qinf & w_x_eq & w_y_eq);

  always_comb begin
    w_triv  = 1'b1;
    w_t_inf = 1'b0;
    w_t_x   = '0;
    w_t_y   = '0;
    if (!r_mode && r_pinf) begin
      w_t_inf = r_qinf;
      w_t_x   = r_qinf ? '0 : r_qx;
      w_t_y   = r_qinf ? '0 : r_qy;
    end else if (!r_mode && r_qinf) begin
      w_t_x = r_px;
      w_t_y = r_py;
    end else if (!r_mode && w_x_eq && !w_y_eq) begin
      w_t_inf = 1'b1;
    end else if (w_dbl && (r_pinf || r_py == '0)) begin
      w_t_inf = 1'b1;
    end else begin
      w_triv = 1'b0;
    end
  end

  // Multiplier step: acc = 2*acc (+ a when the current MSB of b is set).
  logic [WIDTH-1:0] w_acc2, w_mul_step;
  logic             w_mul_last;
  assign w_acc2     = f_add(r_mul_acc, r_mul_acc);
  assign w_mul_step = r_mul_b[WIDTH-1] ? f_add(w_acc2, r_mul_a) : w_acc2;
  assign w_mul_last = (r_cnt == CW'(WIDTH - 1));

  // Inverter step; invariants x1*den = u and x2*den = v (mod PRIME).
  // Subtract and halve share a cycle so u*v at least halves per iteration.
  logic             w_inv_done;
  logic [WIDTH-1:0] w_inv, w_u_n, w_v_n, w_x1_n, w_x2_n;
  assign w_inv_done = (r_u == WIDTH'(1)) || (r_v == WIDTH'(1)) || (r_cnt == CW'(2 * WIDTH));
  assign w_inv      = (r_u == WIDTH'(1)) ? r_x1 : r_x2;

  always_comb begin
    w_u_n  = r_u;
    w_v_n  = r_v;
    w_x1_n = r_x1;
    w_x2_n = r_x2;
    if (!r_u[0]) begin
      w_u_n  = r_u >> 1;
      w_x1_n = f_half(r_x1);
    end else if (!r_v[0]) begin
      w_v_n  = r_v >> 1;
      w_x2_n = f_half(r_x2);
    end else if (r_u >= r_v) begin
      w_u_n  = (r_u - r_v) >> 1;
      w_x1_n = f_half(f_sub(r_x1, r_x2));
    end else begin
      w_v_n  = (r_v - r_u) >> 1;
      w_x2_n = f_half(f_sub(r_x2, r_x1));
    end
  end

  logic [WIDTH-1:0] w_rx_new;
  assign w_rx_new = f_sub(r_t, r_dbl ? r_px : r_qx);

  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next     = r_state;
    io_bus.in_ready  = 1'b0;
    io_bus.out_valid = 1'b0;
    unique case (r_state)
      StIdle: begin
        io_bus.in_ready = 1'b1;
        if (io_bus.in_valid) w_state_next = StCheck;
      end
      StCheck: w_state_next = w_triv ? StDone : StNum;
      StNum:   if (!r_dbl || w_mul_last) w_state_next = StInv;
      StInv:   if (w_inv_done) w_state_next = StLam;
      StLam:   if (w_mul_last) w_state_next = StSq;
      StSq:    if (w_mul_last) w_state_next = StSub1;
      StSub1:  w_state_next = StSub2;
      StSub2:  w_state_next = StYm;
      StYm:    if (w_mul_last) w_state_next = StDone;
      StDone: begin
        io_bus.out_valid = 1'b1;
        w_state_next     = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign io_bus.rx    = r_rx;
  assign io_bus.ry    = r_ry;
  assign io_bus.r_inf = r_rinf;

  always_ff @(posedge clk) begin
    if (rst) begin
      {r_mode, r_pinf, r_qinf, r_dbl, r_rinf} <= '0;
      {r_px, r_py, r_qx, r_qy}                <= '0;
      {r_num, r_u, r_v, r_x1, r_x2, r_lam}    <= '0;
      {r_t, r_mul_a, r_mul_b, r_mul_acc}      <= '0;
      {r_rx, r_ry}                            <= '0;
      r_cnt                                   <= '0;
    end else begin
      unique case (r_state)
        StIdle: if (io_bus.in_valid) begin
          r_mode <= io_bus.mode;
          r_px   <= io_bus.px;
          r_py   <= io_bus.py;
          r_pinf <= io_bus.p_inf;
          r_qx   <= io_bus.qx;
          r_qy   <= io_bus.qy;
          r_qinf <= io_bus.q_inf;
        end
        StCheck: begin
          r_dbl <= w_dbl;
          if (w_triv) begin
            r_rx   <= w_t_x;
            r_ry   <= w_t_y;
            r_rinf <= w_t_inf;
          end else begin
            // Px^2 is only consumed on the double path; harmless for add.
            r_mul_a   <= r_px;
            r_mul_b   <= r_px;
            r_mul_acc <= '0;
            r_cnt     <= '0;
          end
        end
        StNum: begin
          if (!r_dbl || w_mul_last) begin
            r_num <= r_dbl ? f_add(f_add(f_add(w_mul_step, w_mul_step), w_mul_step), A)
                           : f_sub(r_qy, r_py);
            r_u   <= r_dbl ? f_add(r_py, r_py) : f_sub(r_qx, r_px);
            r_v   <= PRIME;
            r_x1  <= WIDTH'(1);
            r_x2  <= '0;
            r_cnt <= '0;
          end else begin
            r_mul_acc <= w_mul_step;
            r_mul_b   <= r_mul_b << 1;
            r_cnt     <= r_cnt + CW'(1);
          end
        end
        StInv: begin
          if (w_inv_done) begin
            r_mul_a   <= r_num;
            r_mul_b   <= w_inv;
            r_mul_acc <= '0;
            r_cnt     <= '0;
          end else begin
            r_u   <= w_u_n;
            r_v   <= w_v_n;
            r_x1  <= w_x1_n;
            r_x2  <= w_x2_n;
            r_cnt <= r_cnt + CW'(1);
          end
        end
        StLam, StSq, StYm: begin
          if (w_mul_last) begin
            r_mul_acc <= '0;
            r_cnt     <= '0;
            if (r_state == StLam) begin
              r_lam   <= w_mul_step;
              r_mul_a <= w_mul_step;
              r_mul_b <= w_mul_step;
            end else if (r_state == StSq) begin
              r_t <= w_mul_step;
            end else begin
              r_rx   <= r_t;
              r_ry   <= f_sub(w_mul_step, r_py);
              r_rinf <= 1'b0;
            end
          end else begin
            r_mul_acc <= w_mul_step;
            r_mul_b   <= r_mul_b << 1;
            r_cnt     <= r_cnt + CW'(1);
          end
        end
        StSub1: r_t <= f_sub(r_t, r_px);
        StSub2: begin
          r_t       <= w_rx_new;
          r_mul_a   <= r_lam;
          r_mul_b   <= f_sub(r_px, w_rx_new);
          r_mul_acc <= '0;
          r_cnt     <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ec_point_unit.sv
// Directed bench: small curve y^2 = x^3 + 2x + 2 over GF(17) with G = (5,1),
// plus one doubling of the secp256k1 generator at default parameters.
module tb_ec_point_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ec_point_unit_if #(.WIDTH(8))   bus_s ();
  ec_point_unit_if #(.WIDTH(256)) bus_b ();

  ec_point_unit #(.WIDTH(8), .PRIME(8'd17), .A(8'd2)) dut_s (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus_s)
  );

  ec_point_unit dut_b (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic m, input logic [7:0] px, input logic [7:0] py,
                       input logic pinf, input logic [7:0] qx, input logic [7:0] qy,
                       input logic qinf);
    bus_s.mode  = m;
    bus_s.px    = px;
    bus_s.py    = py;
    bus_s.p_inf = pinf;
    bus_s.qx    = qx;
    bus_s.qy    = qy;
    bus_s.q_inf = qinf;
  endtask

  // Presents a request for one accept edge; returns #1 after that edge.
  task automatic send(input logic m, input logic [7:0] px, input logic [7:0] py,
                      input logic pinf, input logic [7:0] qx, input logic [7:0] qy,
                      input logic qinf);
    check_eq("ready before send", bus_s.in_ready, 1);
    drive(m, px, py, pinf, qx, qy, qinf);
    bus_s.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus_s.in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input int max_cyc);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus_s.out_valid && n < max_cyc);
    check_eq({tag, " out_valid"}, bus_s.out_valid, 1);
  endtask

  task automatic check_res(input string tag, input logic [7:0] x, input logic [7:0] y,
                           input logic inf);
    check_eq({tag, " rx"}, bus_s.rx, x);
    check_eq({tag, " ry"}, bus_s.ry, y);
    check_eq({tag, " r_inf"}, bus_s.r_inf, inf);
  endtask

  localparam int unsigned MAX_S = 6 * 8 + 16;
  localparam int unsigned MAX_B = 6 * 256 + 16;

  initial begin
    logic seen;
    int   n;
    bus_s.in_valid = 1'b0;
    drive(1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0, 1'b0);
    bus_b.in_valid = 1'b0;
    bus_b.mode     = 1'b1;
    bus_b.px       = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
    bus_b.py       = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;
    bus_b.p_inf    = 1'b0;
    bus_b.qx       = '0;
    bus_b.qy       = '0;
    bus_b.q_inf    = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("reset in_ready", bus_s.in_ready, 1);
    check_eq("reset out_valid", bus_s.out_valid, 0);
    check_res("reset", 8'd0, 8'd0, 1'b0);

    // Double G
    send(1'b1, 8'd5, 8'd1, 1'b0, 8'd0, 8'd0, 1'b0);
    wait_out("dbl G", MAX_S);
    check_res("dbl G", 8'd6, 8'd3, 1'b0);
    @(posedge clk);
    #1;
    check_eq("pulse one cycle", bus_s.out_valid, 0);

    // G + 2G
    send(1'b0, 8'd5, 8'd1, 1'b0, 8'd6, 8'd3, 1'b0);
    wait_out("G+2G", MAX_S);
    check_res("G+2G", 8'd10, 8'd6, 1'b0);
    @(posedge clk);
    #1;

    // G + G through the add request
    send(1'b0, 8'd5, 8'd1, 1'b0, 8'd5, 8'd1, 1'b0);
    wait_out("G+G", MAX_S);
    check_res("G+G", 8'd6, 8'd3, 1'b0);
    @(posedge clk);
    #1;

    // G + (-G): infinity, exactly two cycles after accept
    send(1'b0, 8'd5, 8'd1, 1'b0, 8'd5, 8'd16, 1'b0);
    check_eq("G-G lat1 out_valid", bus_s.out_valid, 0);
    @(posedge clk);
    #1;
    check_eq("G-G lat2 out_valid", bus_s.out_valid, 1);
    check_res("G-G", 8'd0, 8'd0, 1'b1);
    @(posedge clk);
    #1;

    // inf + 2G
    send(1'b0, 8'd0, 8'd0, 1'b1, 8'd6, 8'd3, 1'b0);
    wait_out("inf+2G", 4);
    check_res("inf+2G", 8'd6, 8'd3, 1'b0);
    @(posedge clk);
    #1;

    // Double a point with y = 0
    send(1'b1, 8'd3, 8'd0, 1'b0, 8'd0, 8'd0, 1'b0);
    wait_out("dbl y0", 4);
    check_res("dbl y0", 8'd0, 8'd0, 1'b1);
    @(posedge clk);
    #1;

    // in_valid held high while busy, request changes after accept
    drive(1'b0, 8'd5, 8'd1, 1'b0, 8'd6, 8'd3, 1'b0);
    bus_s.in_valid = 1'b1;
    @(posedge clk);
    #1;
    check_eq("busy in_ready", bus_s.in_ready, 0);
    drive(1'b1, 8'd5, 8'd1, 1'b0, 8'd0, 8'd0, 1'b0);
    wait_out("hold first", MAX_S);
    check_res("hold first", 8'd10, 8'd6, 1'b0);
    @(posedge clk);
    #1;
    check_eq("hold ready back", bus_s.in_ready, 1);
    @(posedge clk);
    #1;
    check_eq("hold second accepted", bus_s.in_ready, 0);
    bus_s.in_valid = 1'b0;
    wait_out("hold second", MAX_S);
    check_res("hold second", 8'd6, 8'd3, 1'b0);
    @(posedge clk);
    #1;

    // Reset while the inverter is running (double G reaches INV after ~9 cycles)
    send(1'b1, 8'd5, 8'd1, 1'b0, 8'd0, 8'd0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("abort in_ready", bus_s.in_ready, 1);
    check_eq("abort out_valid", bus_s.out_valid, 0);
    check_res("abort", 8'd0, 8'd0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < MAX_S; i++) begin
      @(posedge clk);
      #1;
      seen = seen | bus_s.out_valid;
    end
    check_eq("abort no out_valid", seen, 0);
    send(1'b1, 8'd5, 8'd1, 1'b0, 8'd0, 8'd0, 1'b0);
    wait_out("after abort", MAX_S);
    check_res("after abort", 8'd6, 8'd3, 1'b0);

    // secp256k1: 2G at default parameters
    @(posedge clk);
    #1;
    check_eq("k1 ready", bus_b.in_ready, 1);
    bus_b.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus_b.in_valid = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus_b.out_valid && n < MAX_B);
    check_eq("k1 out_valid", bus_b.out_valid, 1);
    check_eq("k1 rx", bus_b.rx,
             256'hC6047F9441ED7D6D3045406E95C07CD85C778E4B8CEF3CA7ABAC09B95C709EE5);
    check_eq("k1 ry", bus_b.ry,
             256'h1AE168FEA63DC339A3C58419466CEAEEF7F632653266D0E1236431A950CFE52A);
    check_eq("k1 r_inf", bus_b.r_inf, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/ec_point_unit.md
Name: ec_point_unit

Overview:
- Parametrised successor to the fixed 256-bit affine point adder.
- Computes R = P + Q or R = 2P on a short-Weierstrass curve y^2 = x^3 + A·x + B over GF(PRIME).
- Prime, curve coefficient and operand width are generics. Handles the point at infinity and the P = Q / P = -Q degenerate cases.
- Iterative, single-issue: one bit-serial modular multiplier and one binary-extended-Euclid inverter, sequenced by an FSM. Sits under the scalar-multiply controller.

Parameters:
- WIDTH, 256, operand/coordinate width in bits
- PRIME, secp256k1 p (2^256-2^32-977), field modulus; odd, < 2^WIDTH
- A, 0, curve coefficient a (B not needed)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  request strobe; accepted only when in_ready=1
- in_ready  out  1  high in IDLE only
- mode  in  1  0 = add P+Q, 1 = double 2P (Q ignored)
- Px, Py  in  WIDTH  point P, each < PRIME
- P_inf  in  1  P is the point at infinity
- Qx, Qy  in  WIDTH  point Q, each < PRIME
- Q_inf  in  1  Q is the point at infinity
- Rx, Ry  out  WIDTH  result coordinates; 0 when R_inf=1
- R_inf  out  1  result is the point at infinity
- out_valid  out  1  one-cycle pulse; Rx/Ry/R_inf valid in the same cycle and held until the next accept

Behaviour:
Reset and handshake:
- Reset: state IDLE; Rx=Ry=0, R_inf=0, out_valid=0, in_ready=1; all internal registers cleared.
- rst mid-operation aborts the computation; no out_valid is produced.
- Accept occurs when in_valid & in_ready. Inputs are registered at accept. in_valid while busy is ignored, not queued.

FSM states:
- IDLE -> CHECK on accept.
- CHECK classifies the request:
  - add, P_inf: R = Q (including Q_inf).
  - add, Q_inf: R = P.
  - add, Px=Qx and Py≠Qy: R = inf.
  - add, Px=Qx and Py=Qy: treat as double.
  - double with P_inf or Py=0: R = inf.
  - Trivial cases go to DONE. Otherwise -> NUM.
- NUM:
  - add: num = Qy-Py, den = Qx-Px, both mod PRIME.
  - double: MUL Px·Px, then num = 3·Px^2 + A, den = 2·Py.
- INV: den^-1 by binary extended Euclid; at most 2·WIDTH iterations, one per cycle.
- LAM: MUL lambda = num·den^-1.
- SQ: MUL lambda^2; then Rx = lambda^2 - Px - Qx' (Qx' = Px for double), two modular subtracts, one cycle each.
- YM: MUL lambda·(Px-Rx); then Ry = result - Py.
- DONE: drive outputs and pulse out_valid for one cycle -> IDLE (in_ready=1 in the next cycle).

Arithmetic rules:
- MUL is MSB-first interleaved: WIDTH cycles, accumulator kept < PRIME by conditional subtract(s) each step.
- Modular add/sub: WIDTH+1-bit intermediate, single conditional correction.
- All results are fully reduced to [0, PRIME).

Latency:
- Trivial cases: out_valid exactly 2 cycles after the accept cycle.
- General case: at most 6·WIDTH+16 cycles.
- Result is data-independent of timing; only INV length varies.

Inputs ≥ PRIME are out of contract; behaviour is unspecified but the FSM must still return to IDLE.

Test Plan:
Bench uses WIDTH=8, PRIME=17, A=2 (curve y^2=x^3+2x+2); G=(5,1).
- mode=1, P=(5,1) -> R=(6,3), R_inf=0, out_valid within 6·8+16 cycles.
- mode=0, P=(5,1), Q=(6,3) -> R=(10,6); mode=0, P=Q=(5,1) -> R=(6,3) via double path.
- mode=0, P=(5,1), Q=(5,16) -> R_inf=1, Rx=Ry=0, exactly 2 cycles after accept; P_inf=1, Q=(6,3) -> R=(6,3); mode=1, P=(x,0) -> R_inf=1.
- in_valid held high throughout the (5,1)+(6,3) operation with a different second request -> only the first result produced; second request accepted on the cycle in_ready returns.
- rst=1 asserted mid-INV -> no out_valid, outputs 0, in_ready=1 the next cycle; a new request then completes correctly.
- Default parameters, secp256k1 generator doubled -> Rx=0xC6047F9441ED7D6D3045406E95C07CD85C778E4B8CEF3CA7ABAC09B95C709EE5, Ry=0x1AE168FEA63DC339A3C58419466CEAEEF7F632653266D0E1236431A950CFE52A.
